// File: rtl/cr_huf_comp_ph_loader.sv
// Loads one predetermined Huffman table (long words, then short words) from an input
// stream into a selected slot of the predet memories, tracking which slots hold complete tables.
module cr_huf_comp_ph_loader #(
    parameter int unsigned NUM_TBL    = 10,
    parameter int unsigned LONG_DEPTH = 22,
    parameter int unsigned SHRT_DEPTH = 48,
    parameter int unsigned DW         = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_req,
    input  logic [3:0]         load_id,
    output logic               load_ack,
    output logic               load_err,
    input  logic               in_vld,
    input  logic [DW-1:0]      in_data,
    output logic               in_rdy,
    input  logic               abort,
    input  logic [NUM_TBL-1:0] slot_busy,
    output logic               long_wr,
    output logic [4:0]         long_addr,
    output logic               shrt_wr,
    output logic [5:0]         shrt_addr,
    output logic [3:0]         wr_mem_id,
    output logic [DW-1:0]      wr_data,
    output logic [NUM_TBL-1:0] tbl_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LONG = 3'd2,
        ST_SHRT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_r;
    logic [5:0]         cnt_r;
    logic [3:0]         id_r;
    logic [NUM_TBL-1:0] tbl_valid_r;
    logic               load_ack_r;
    logic               load_err_r;
    logic               in_rdy_r;
    logic               long_wr_r;
    logic [4:0]         long_addr_r;
    logic               shrt_wr_r;
    logic [5:0]         shrt_addr_r;
    logic [3:0]         wr_mem_id_r;
    logic [DW-1:0]      wr_data_r;
    logic               busy_r;
    logic               done_r;

    logic accept_s;
    logic id_bad_s;
    logic long_last_s;
    logic shrt_last_s;
    logic slot_held_s;

    // Handshake, range check and end-of-table decodes feeding the FSM.
    always_comb begin
        accept_s    = in_vld && in_rdy_r;
        id_bad_s    = ({28'd0, load_id} >= NUM_TBL);
        long_last_s = (cnt_r == 6'(LONG_DEPTH - 32'd1));
        shrt_last_s = (cnt_r == 6'(SHRT_DEPTH - 32'd1));
        slot_held_s = slot_busy[id_r];
    end

    // Load FSM with all outputs registered; in_rdy and busy track the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 6'd0;
            id_r        <= 4'd0;
            tbl_valid_r <= '0;
            load_ack_r  <= 1'b0;
            load_err_r  <= 1'b0;
            in_rdy_r    <= 1'b0;
            long_wr_r   <= 1'b0;
            long_addr_r <= 5'd0;
            shrt_wr_r   <= 1'b0;
            shrt_addr_r <= 6'd0;
            wr_mem_id_r <= 4'd0;
            wr_data_r   <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            load_ack_r <= 1'b0;
            load_err_r <= 1'b0;
            long_wr_r  <= 1'b0;
            shrt_wr_r  <= 1'b0;
            done_r     <= 1'b0;

            // A word accepted on this edge is written next cycle, even if abort moves the FSM away.
            if (accept_s) begin
                wr_data_r   <= in_data;
                wr_mem_id_r <= id_r;
                if (state_r == ST_LONG) begin
                    long_wr_r   <= 1'b1;
                    long_addr_r <= cnt_r[4:0];
                end else begin
                    shrt_wr_r   <= 1'b1;
                    shrt_addr_r <= cnt_r;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (load_req) begin
                        load_ack_r <= 1'b1;
                        if (id_bad_s) begin
                            load_err_r <= 1'b1;
                        end else begin
                            id_r                 <= load_id;
                            tbl_valid_r[load_id] <= 1'b0;
                            state_r              <= ST_WAIT;
                            busy_r               <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (!slot_held_s) begin
                        state_r  <= ST_LONG;
                        cnt_r    <= 6'd0;
                        in_rdy_r <= 1'b1;
                    end
                end
                ST_LONG: begin
                    if (abort) begin
                        state_r  <= ST_IDLE;
                        cnt_r    <= 6'd0;
                        in_rdy_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end else if (accept_s) begin
                        if (long_last_s) begin
                            state_r <= ST_SHRT;
                            cnt_r   <= 6'd0;
                        end else begin
                            cnt_r <= cnt_r + 6'd1;
                        end
                    end
                end
                ST_SHRT: begin
                    if (abort) begin
                        state_r  <= ST_IDLE;
                        cnt_r    <= 6'd0;
                        in_rdy_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end else if (accept_s) begin
                        if (shrt_last_s) begin
                            state_r  <= ST_DONE;
                            cnt_r    <= 6'd0;
                            in_rdy_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + 6'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r           <= ST_IDLE;
                    done_r            <= 1'b1;
                    tbl_valid_r[id_r] <= 1'b1;
                    busy_r            <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= 6'd0;
                    in_rdy_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign load_ack  = load_ack_r;
    assign load_err  = load_err_r;
    assign in_rdy    = in_rdy_r;
    assign long_wr   = long_wr_r;
    assign long_addr = long_addr_r;
    assign shrt_wr   = shrt_wr_r;
    assign shrt_addr = shrt_addr_r;
    assign wr_mem_id = wr_mem_id_r;
    assign wr_data   = wr_data_r;
    assign tbl_valid = tbl_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_cr_huf_comp_ph_loader.sv
// Randomized self-checking bench: expected write streams are built from the table layout
// (long words at addresses 0..21, then short words at 0..47) and compared with captured writes.
module tb_cr_huf_comp_ph_loader;

    localparam int NT = 10;
    localparam int DW = 60;
    localparam int NWORDS = 70;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_req = 1'b0;
    logic [3:0]    load_id = 4'd0;
    logic          load_ack, load_err;
    logic          in_vld = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_rdy;
    logic          abort = 1'b0;
    logic [NT-1:0] slot_busy = '0;
    logic          long_wr, shrt_wr;
    logic [4:0]    long_addr;
    logic [5:0]    shrt_addr;
    logic [3:0]    wr_mem_id;
    logic [DW-1:0] wr_data;
    logic [NT-1:0] tbl_valid;
    logic          busy, done;

    cr_huf_comp_ph_loader dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_id(load_id),
        .load_ack(load_ack), .load_err(load_err), .in_vld(in_vld), .in_data(in_data),
        .in_rdy(in_rdy), .abort(abort), .slot_busy(slot_busy), .long_wr(long_wr),
        .long_addr(long_addr), .shrt_wr(shrt_wr), .shrt_addr(shrt_addr),
        .wr_mem_id(wr_mem_id), .wr_data(wr_data), .tbl_valid(tbl_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          s;
        logic [5:0]    a;
        logic [3:0]    id;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           got_q[$];
    wr_t           exp_q[$];
    logic [DW-1:0] words[NWORDS];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int dual_cnt = 0;
    int ack_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (long_wr) got_q.push_back(wr_t'{s: 1'b0, a: {1'b0, long_addr}, id: wr_mem_id, d: wr_data});
            if (shrt_wr) got_q.push_back(wr_t'{s: 1'b1, a: shrt_addr, id: wr_mem_id, d: wr_data});
            if (long_wr && shrt_wr) dual_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic fill_words();
        for (int i = 0; i < NWORDS; i++) words[i] = {28'($urandom), 32'($urandom)};
    endtask

    // Reference: a table is LONG_DEPTH long words then SHRT_DEPTH short words, in stream order.
    task automatic build_exp(input logic [3:0] tid);
        exp_q.delete();
        for (int i = 0; i < 22; i++) exp_q.push_back(wr_t'{s: 1'b0, a: 6'(i), id: tid, d: words[i]});
        for (int i = 0; i < 48; i++) exp_q.push_back(wr_t'{s: 1'b1, a: 6'(i), id: tid, d: words[22+i]});
    endtask

    function automatic int first_diff(input int n);
        for (int i = 0; i < n; i++) begin
            if (i >= got_q.size()) return i;
            if (got_q[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    task automatic request(input logic [3:0] id, output logic got, output logic err);
        load_req = 1'b1;
        load_id  = id;
        got = 1'b0;
        err = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (load_ack) begin
                got = 1'b1;
                err = load_err;
                ack_cyc = cyc;
            end
        end
        load_req = 1'b0;
    endtask

    // mode 0: back-to-back, 1: in_vld toggles every cycle, 2: random gaps.
    task automatic stream(input int n, input int mode, output int acc);
        int idx = 0;
        int budget = 3000;
        logic tog = 1'b1;
        logic r, v;
        while (idx < n && budget > 0) begin
            r = in_rdy;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            in_vld  = v;
            in_data = words[idx];
            if (r && v) idx++;
            @(negedge clk);
            budget--;
        end
        in_vld = 1'b0;
        acc = idx;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [84:0] outs;
        idle(3);
        outs = {load_ack, load_err, in_rdy, long_wr, shrt_wr, long_addr, shrt_addr,
                wr_mem_id, wr_data, busy, done};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
        total++;
        if (tbl_valid !== '0) begin bad++; $display("FAIL reset_tbl_valid got=%h want=0", tbl_valid); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        logic got, err;
        int acc, d0, fd;
        fill_words();
        build_exp(4'd3);
        got_q.delete();
        d0 = done_cnt;
        request(4'd3, got, err);
        total++;
        if (!got || err) begin bad++; $display("FAIL basic_ack got=%b err=%b want=1,0", got, err); end
        stream(NWORDS, 0, acc);
        idle(5);
        total++;
        if (got_q.size() != NWORDS) begin bad++; $display("FAIL basic_count got=%0d want=%0d", got_q.size(), NWORDS); end
        fd = first_diff(NWORDS);
        total++;
        if (fd != -1) begin bad++; $display("FAIL basic_seq first bad index=%0d want=-1", fd); end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt - d0); end
        total++;
        if (done_cyc - ack_cyc != 72) begin bad++; $display("FAIL basic_done_latency got=%0d want=72", done_cyc - ack_cyc); end
        total++;
        if (tbl_valid !== 10'h008) begin bad++; $display("FAIL basic_tbl_valid got=%h want=008", tbl_valid); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", busy); end
    endtask

    task automatic test_bad_id();
        logic got, err, saw_busy;
        logic [3:0] ids[2];
        ids[0] = 4'd10;
        ids[1] = 4'($urandom_range(11, 15));
        for (int t = 0; t < 2; t++) begin
            got_q.delete();
            saw_busy = 1'b0;
            request(ids[t], got, err);
            total++;
            if ({got, err} !== 2'b11) begin bad++; $display("FAIL badid_ack_err id=%0d got=%b%b want=11", ids[t], got, err); end
            idle(1);
            total++;
            if (load_ack !== 1'b0) begin bad++; $display("FAIL badid_ack_pulse got=%b want=0", load_ack); end
            for (int k = 0; k < 4; k++) begin
                if (busy) saw_busy = 1'b1;
                @(negedge clk);
            end
            total++;
            if (saw_busy || got_q.size() != 0) begin
                bad++; $display("FAIL badid_quiet busy=%b writes=%0d want=0,0", saw_busy, got_q.size());
            end
        end
        total++;
        if (tbl_valid !== 10'h008) begin bad++; $display("FAIL badid_tbl_valid got=%h want=008", tbl_valid); end
    endtask

    task automatic test_busy_slot();
        logic got, err, saw_rdy;
        int acc, fd;
        fill_words();
        build_exp(4'd5);
        got_q.delete();
        slot_busy = 10'h020;
        saw_rdy = 1'b0;
        request(4'd5, got, err);
        for (int k = 0; k < 20; k++) begin
            in_vld = 1'b1;
            if (in_rdy) saw_rdy = 1'b1;
            @(negedge clk);
        end
        in_vld = 1'b0;
        total++;
        if (saw_rdy || !busy) begin bad++; $display("FAIL busy_hold rdy_seen=%b busy=%b want=0,1", saw_rdy, busy); end
        slot_busy = '0;
        stream(NWORDS, 2, acc);
        idle(5);
        fd = first_diff(NWORDS);
        total++;
        if (fd != -1 || got_q.size() != NWORDS) begin
            bad++; $display("FAIL busy_seq bad index=%0d writes=%0d want=-1,70", fd, got_q.size());
        end
        total++;
        if (tbl_valid !== 10'h028) begin bad++; $display("FAIL busy_tbl_valid got=%h want=028", tbl_valid); end
    endtask

    task automatic test_abort();
        logic got, err;
        int acc, d0, fd, ns;
        fill_words();
        build_exp(4'd7);
        got_q.delete();
        d0 = done_cnt;
        request(4'd7, got, err);
        stream(30, 0, acc);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        idle(5);
        ns = 0;
        foreach (got_q[i]) if (got_q[i].s) ns++;
        total++;
        if (got_q.size() != 30 || ns != 8) begin
            bad++; $display("FAIL abort_count writes=%0d short=%0d want=30,8", got_q.size(), ns);
        end
        fd = first_diff(30);
        total++;
        if (fd != -1) begin bad++; $display("FAIL abort_seq first bad index=%0d want=-1", fd); end
        total++;
        if (busy || in_rdy || done_cnt != d0) begin
            bad++; $display("FAIL abort_idle busy=%b rdy=%b dones=%0d want=0,0,0", busy, in_rdy, done_cnt - d0);
        end
        total++;
        if (tbl_valid !== 10'h028) begin bad++; $display("FAIL abort_tbl_valid got=%h want=028", tbl_valid); end
    endtask

    task automatic test_throttle_reload();
        logic got, err;
        int acc, fd;
        fill_words();
        build_exp(4'd3);
        got_q.delete();
        request(4'd3, got, err);
        total++;
        if (tbl_valid !== 10'h020) begin bad++; $display("FAIL reload_clear got=%h want=020", tbl_valid); end
        stream(NWORDS, 1, acc);
        idle(5);
        fd = first_diff(NWORDS);
        total++;
        if (fd != -1 || got_q.size() != NWORDS) begin
            bad++; $display("FAIL throttle_seq bad index=%0d writes=%0d want=-1,70", fd, got_q.size());
        end
        total++;
        if (tbl_valid !== 10'h028 || dual_cnt != 0) begin
            bad++; $display("FAIL reload_set tbl_valid=%h dual=%0d want=028,0", tbl_valid, dual_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic got, err;
        logic [84:0] outs;
        int acc, fd;
        fill_words();
        request(4'd9, got, err);
        stream(40, 0, acc);
        rst_n = 1'b0;
        #1;
        outs = {load_ack, load_err, in_rdy, long_wr, shrt_wr, long_addr, shrt_addr,
                wr_mem_id, wr_data, busy, done};
        total++;
        if (outs !== '0 || tbl_valid !== '0) begin
            bad++; $display("FAIL midreset_outputs outs=%h tbl_valid=%h want=0,0", outs, tbl_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        fill_words();
        build_exp(4'd2);
        got_q.delete();
        request(4'd2, got, err);
        stream(NWORDS, 2, acc);
        idle(5);
        fd = first_diff(NWORDS);
        total++;
        if (fd != -1 || got_q.size() != NWORDS) begin
            bad++; $display("FAIL midreset_reload bad index=%0d writes=%0d want=-1,70", fd, got_q.size());
        end
        total++;
        if (tbl_valid !== 10'h004) begin bad++; $display("FAIL midreset_tbl_valid got=%h want=004", tbl_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_id();
        test_busy_slot();
        test_abort();
        test_throttle_reload();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
